// File: rtl/conv1x1_acc.sv
// conv1x1_acc: multi-channel 1x1 convolution accumulator.
// Streams CIN channel beats per output pixel, sums x*w across them on top of
// a bias sampled on channel 0, and hands one result per pixel to a
// valid/ready output slot with backpressure.
module conv1x1_acc #(
  parameter int WIDTH = 16,
  parameter int CIN   = 4,
  parameter int ACC_W = 2*WIDTH + $clog2(CIN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // Counter is at least one bit wide so CIN==1 still elaborates cleanly;
  // in that case it simply stays at zero and every beat is a last beat.
  localparam int CNT_W = (CIN > 1) ? $clog2(CIN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CIN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;

  logic             last_beat;
  logic             accept;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] term;

  // Handshake and single-cycle multiply-add; ACC_W is wide enough that the
  // zero-extended sum can never overflow.
  always_comb begin
    last_beat = (cnt_q == LAST_CNT);
    in_ready  = !flush && !(last_beat && out_valid_q && !out_ready);
    accept    = in_valid && in_ready;
    prod      = ACC_W'(x) * ACC_W'(w);
    term      = ((cnt_q == '0) ? ACC_W'(b) : acc_q) + prod;
  end

  // Next-state: drain the output slot, then apply flush or an accepted beat.
  // A last beat landing in the same cycle as a drain refills the slot, so
  // out_valid stays high with no bubble.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        y_d         = term;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
      end else begin
        acc_d = term;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_conv1x1_acc.sv
// Self-checking bench for conv1x1_acc: table-driven CIN=4 vectors plus
// hand-written sequences for asynchronous reset mid-pixel and a CIN=1 build.
module tb_conv1x1_acc;

  localparam int WIDTH = 16;
  localparam int ACC_W = 35;   // 2*16 + clog2(5)
  localparam int ACC1_W = 33;  // 2*16 + clog2(2)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // CIN=4 instance
  logic             flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] x, w, b;
  logic [ACC_W-1:0] y;

  // CIN=1 instance
  logic              flush1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [WIDTH-1:0]  x1, w1, b1;
  logic [ACC1_W-1:0] y1;

  conv1x1_acc #(.WIDTH(WIDTH), .CIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .x(x), .w(w), .b(b), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  conv1x1_acc #(.WIDTH(WIDTH), .CIN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1),
    .in_ready(in_ready1), .x(x1), .w(w1), .b(b1), .y(y1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] b;
    logic        v;
    logic        ordy;
    logic        fl;
    logic        exp_ir;    // in_ready during the cycle
    logic        exp_ov;    // out_valid after the edge
    logic        exp_busy;  // busy after the edge
    logic [34:0] exp_y;     // y after the edge
  } vec_t;

  localparam int NV = 42;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input logic [15:0] vx, input logic [15:0] vw,
                              input logic [15:0] vb, input logic vv,
                              input logic vo, input logic vf,
                              input logic eir, input logic eov,
                              input logic ebusy, input logic [34:0] ey);
    vec_t r;
    r.x = vx; r.w = vw; r.b = vb; r.v = vv; r.ordy = vo; r.fl = vf;
    r.exp_ir = eir; r.exp_ov = eov; r.exp_busy = ebusy; r.exp_y = ey;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered at posedge+1: drive, check in_ready, clock, check registered outputs.
  task automatic apply(input int idx, input vec_t v);
    x = v.x; w = v.w; b = v.b; in_valid = v.v; out_ready = v.ordy; flush = v.fl;
    #1;
    chk($sformatf("row%0d in_ready", idx), 64'(in_ready), 64'(v.exp_ir));
    @(posedge clk); #1;
    chk($sformatf("row%0d out_valid", idx), 64'(out_valid), 64'(v.exp_ov));
    chk($sformatf("row%0d y", idx), 64'(y), 64'(v.exp_y));
    chk($sformatf("row%0d busy", idx), 64'(busy), 64'(v.exp_busy));
    $display("row %0d: x=%0d w=%0d b=%0d v=%0d ordy=%0d fl=%0d -> y=%0d ov=%0d busy=%0d",
             idx, v.x, v.w, v.b, v.v, v.ordy, v.fl, y, out_valid, busy);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic pixel A, out_ready=1
    tbl[0]  = mk(1, 2, 5, 1, 1, 0, 1, 0, 1, 0);
    tbl[1]  = mk(3, 4, 0, 1, 1, 0, 1, 0, 1, 0);
    tbl[2]  = mk(5, 6, 0, 1, 1, 0, 1, 0, 1, 0);
    tbl[3]  = mk(7, 8, 0, 1, 1, 0, 1, 1, 0, 105);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 105);
    // Back-to-back A then B
    tbl[5]  = mk(1, 2, 5, 1, 1, 0, 1, 0, 1, 105);
    tbl[6]  = mk(3, 4, 0, 1, 1, 0, 1, 0, 1, 105);
    tbl[7]  = mk(5, 6, 0, 1, 1, 0, 1, 0, 1, 105);
    tbl[8]  = mk(7, 8, 0, 1, 1, 0, 1, 1, 0, 105);
    tbl[9]  = mk(2, 2, 1, 1, 1, 0, 1, 0, 1, 105);
    tbl[10] = mk(2, 2, 0, 1, 1, 0, 1, 0, 1, 105);
    tbl[11] = mk(2, 2, 0, 1, 1, 0, 1, 0, 1, 105);
    tbl[12] = mk(2, 2, 0, 1, 1, 0, 1, 1, 0, 17);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 17);
    // Backpressure: A completes with out_ready=0, B stalls on its last beat
    tbl[14] = mk(1, 2, 5, 1, 0, 0, 1, 0, 1, 17);
    tbl[15] = mk(3, 4, 0, 1, 0, 0, 1, 0, 1, 17);
    tbl[16] = mk(5, 6, 0, 1, 0, 0, 1, 0, 1, 17);
    tbl[17] = mk(7, 8, 0, 1, 0, 0, 1, 1, 0, 105);
    tbl[18] = mk(2, 2, 1, 1, 0, 0, 1, 1, 1, 105);
    tbl[19] = mk(2, 2, 0, 1, 0, 0, 1, 1, 1, 105);
    tbl[20] = mk(2, 2, 0, 1, 0, 0, 1, 1, 1, 105);
    tbl[21] = mk(2, 2, 0, 1, 0, 0, 0, 1, 1, 105);
    tbl[22] = mk(2, 2, 0, 1, 0, 0, 0, 1, 1, 105);
    tbl[23] = mk(2, 2, 0, 1, 1, 0, 1, 1, 0, 17);
    tbl[24] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 17);
    // Max operands
    tbl[25] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 0, 1, 0, 1, 17);
    tbl[26] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 0, 1, 0, 1, 17);
    tbl[27] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 0, 1, 0, 1, 17);
    tbl[28] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 0, 1, 1, 0, 35'd17179410435);
    tbl[29] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 35'd17179410435);
    // Flush with a result pending: A pending, B partial, flush, new pixel
    tbl[30] = mk(1, 2, 5, 1, 0, 0, 1, 0, 1, 35'd17179410435);
    tbl[31] = mk(3, 4, 0, 1, 0, 0, 1, 0, 1, 35'd17179410435);
    tbl[32] = mk(5, 6, 0, 1, 0, 0, 1, 0, 1, 35'd17179410435);
    tbl[33] = mk(7, 8, 0, 1, 0, 0, 1, 1, 0, 105);
    tbl[34] = mk(2, 2, 1, 1, 0, 0, 1, 1, 1, 105);
    tbl[35] = mk(2, 2, 0, 1, 0, 0, 1, 1, 1, 105);
    tbl[36] = mk(2, 2, 0, 1, 0, 1, 0, 1, 0, 105);
    tbl[37] = mk(1, 1, 0, 1, 0, 0, 1, 1, 1, 105);
    tbl[38] = mk(1, 1, 0, 1, 0, 0, 1, 1, 1, 105);
    tbl[39] = mk(1, 1, 0, 1, 0, 0, 1, 1, 1, 105);
    tbl[40] = mk(1, 1, 0, 1, 1, 0, 1, 1, 0, 4);
    tbl[41] = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 4);

    rst_n = 1'b0;
    flush = 0; in_valid = 0; out_ready = 1; x = 0; w = 0; b = 0;
    flush1 = 0; in_valid1 = 0; out_ready1 = 1; x1 = 0; w1 = 0; b1 = 0;
    #12;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset y", 64'(y), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset cin1 out_valid", 64'(out_valid1), 64'd0);
    #4 rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) apply(i, tbl[i]);

    // Asynchronous reset after 3 beats of a pixel
    apply(100, mk(1, 2, 5, 1, 1, 0, 1, 0, 1, 4));
    apply(101, mk(3, 4, 0, 1, 1, 0, 1, 0, 1, 4));
    apply(102, mk(5, 6, 0, 1, 1, 0, 1, 0, 1, 4));
    #2 rst_n = 1'b0;
    #1;
    chk("midreset y", 64'(y), 64'd0);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    apply(103, mk(1, 2, 5, 1, 1, 0, 1, 0, 1, 0));
    apply(104, mk(3, 4, 0, 1, 1, 0, 1, 0, 1, 0));
    apply(105, mk(5, 6, 0, 1, 1, 0, 1, 0, 1, 0));
    apply(106, mk(7, 8, 0, 1, 1, 0, 1, 1, 0, 105));
    apply(107, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 105));

    // CIN=1: every beat is a full pixel
    x1 = 3; w1 = 4; b1 = 5; in_valid1 = 1'b1;
    #1 chk("cin1 in_ready", 64'(in_ready1), 64'd1);
    @(posedge clk); #1;
    chk("cin1 y0", 64'(y1), 64'd17);
    chk("cin1 ov0", 64'(out_valid1), 64'd1);
    chk("cin1 busy0", 64'(busy1), 64'd0);
    $display("cin1 beat 0: y=%0d ov=%0d", y1, out_valid1);
    x1 = 2; w1 = 7; b1 = 5;
    @(posedge clk); #1;
    chk("cin1 y1", 64'(y1), 64'd19);
    chk("cin1 ov1", 64'(out_valid1), 64'd1);
    $display("cin1 beat 1: y=%0d ov=%0d", y1, out_valid1);
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("cin1 drain ov", 64'(out_valid1), 64'd0);
    chk("cin1 drain y", 64'(y1), 64'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
